// File: rtl/lampfpu_sqrt_post_if.sv
// Operation descriptor, fraction hand-off and result bundle for the sqrt/invsqrt post-processing stage.
interface lampfpu_sqrt_post_if #(
  parameter int FRAC_DW = 16
);
  logic                     start_i;
  logic                     isInv_i;
  logic signed [7:0]        halfExp_i;
  logic                     sign_i;
  logic                     isZero_i;
  logic                     isInf_i;
  logic                     isNaN_i;
  logic                     fracValid_i;
  logic [FRAC_DW-1:0]       frac_i;
  logic [15:0]              res_o;
  logic                     valid_o;
  logic                     busy_o;
  logic                     invalid_o;
  logic                     divByZero_o;
  logic                     err_o;

  modport master (
    output start_i, isInv_i, halfExp_i, sign_i, isZero_i, isInf_i, isNaN_i, fracValid_i, frac_i,
    input  res_o, valid_o, busy_o, invalid_o, divByZero_o, err_o
  );

  modport slave (
    input  start_i, isInv_i, halfExp_i, sign_i, isZero_i, isInf_i, isNaN_i, fracValid_i, frac_i,
    output res_o, valid_o, busy_o, invalid_o, divByZero_o, err_o
  );
endinterface

// File: rtl/lampfpu_sqrt_post.sv
// Sqrt / inverse-sqrt post-processing: resolves special operands, waits for the Q1.15 fraction
// (with watchdog), normalises, rounds to nearest-even and packs a bfloat16 result.
module lampfpu_sqrt_post #(
  parameter int FRAC_DW  = 16,
  parameter int WDOG_CYC = 32
) (
  input logic                clk,
  input logic                rst,
  lampfpu_sqrt_post_if.slave bus
);

  localparam int          CNT_W     = (WDOG_CYC > 1) ? $clog2(WDOG_CYC) : 1;
  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(WDOG_CYC - 1);
  localparam logic [15:0] QNAN      = 16'h7FC0;
  localparam logic [15:0] PINF      = 16'h7F80;

  typedef enum logic [1:0] {IDLE, SPEC, WAIT, RND} state_t;

  typedef struct packed {
    logic [15:0] res;
    logic        invalid;
    logic        dbz;
    logic        err;
  } result_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               isInv_q;
  logic signed [7:0]  halfExp_q;
  logic [FRAC_DW-1:0] frac_q;
  result_t            out_q, out_d;
  logic               valid_q;
  logic               upd;
  logic               special_in;

  function automatic result_t special_result(input logic inv, input logic sgn, input logic zero,
                                             input logic inf, input logic nan);
    result_t r;
    r = '0;
    if (nan) begin
      r.res = QNAN;
    end else if (zero) begin
      r.res = inv ? {sgn, PINF[14:0]} : {sgn, 15'd0};
      r.dbz = inv;
    end else if (sgn) begin
      r.res     = QNAN;
      r.invalid = 1'b1;
    end else begin
      r.res = inv ? 16'h0000 : PINF;
    end
    // inf is the only class left here; its result is fixed above
    if (inf) r.err = 1'b0;
    return r;
  endfunction

  function automatic result_t round_result(input logic inv, input logic signed [7:0] k,
                                           input logic [FRAC_DW-1:0] f);
    result_t           r;
    logic signed [9:0] e;
    logic signed [9:0] be;
    logic [6:0]        mant;
    logic [7:0]        msum;
    logic              guard;
    logic              sticky;
    r = '0;
    e = {{2{k[7]}}, k};
    if (inv) e = -e;
    if (f[FRAC_DW-1]) begin
      mant   = f[FRAC_DW-2 -: 7];
      guard  = f[FRAC_DW-9];
      sticky = |f[FRAC_DW-10:0];
    end else begin
      mant   = f[FRAC_DW-3 -: 7];
      guard  = f[FRAC_DW-10];
      sticky = |f[FRAC_DW-11:0];
      e      = e - 10'sd1;
    end
    msum = {1'b0, mant} + {7'd0, guard & (sticky | mant[0])};
    if (msum[7]) begin
      mant = 7'd0;
      e    = e + 10'sd1;
    end else begin
      mant = msum[6:0];
    end
    be = e + 10'sd127;
    if (f[FRAC_DW-1 -: 2] == 2'b00) begin
      r.res = QNAN;
      r.err = 1'b1;
    end else if (be >= 10'sd255) begin
      r.res = PINF;
    end else if (be <= 10'sd0) begin
      r.res = 16'h0000;
    end else begin
      r.res = {1'b0, be[7:0], mant};
    end
    return r;
  endfunction

  assign special_in = bus.isNaN_i | bus.isZero_i | bus.isInf_i | bus.sign_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= upd;
      if (upd) out_q <= out_d;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == IDLE && bus.start_i) begin
      isInv_q   <= bus.isInv_i;
      halfExp_q <= bus.halfExp_i;
    end
    if (state_q == WAIT && bus.fracValid_i) frac_q <= bus.frac_i;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (bus.start_i) begin
        state_d = special_in ? SPEC : WAIT;
        cnt_d   = '0;
      end
      SPEC: state_d = IDLE;
      WAIT: begin
        if (bus.fracValid_i)        state_d = RND;
        else if (cnt_q == WDOG_LAST) state_d = IDLE;
        else                         cnt_d = cnt_q + CNT_W'(1);
      end
      RND:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Result registers load on the edge that produces a result, so valid_o is a one-cycle strobe
  always_comb begin
    upd   = 1'b0;
    out_d = '0;
    case (state_q)
      IDLE: if (bus.start_i && special_in) begin
        upd   = 1'b1;
        out_d = special_result(bus.isInv_i, bus.sign_i, bus.isZero_i, bus.isInf_i, bus.isNaN_i);
      end
      WAIT: if (!bus.fracValid_i && cnt_q == WDOG_LAST) begin
        upd       = 1'b1;
        out_d.res = QNAN;
        out_d.err = 1'b1;
      end
      RND: begin
        upd   = 1'b1;
        out_d = round_result(isInv_q, halfExp_q, frac_q);
      end
      default: ;
    endcase
  end

  assign bus.res_o       = out_q.res;
  assign bus.invalid_o   = out_q.invalid;
  assign bus.divByZero_o = out_q.dbz;
  assign bus.err_o       = out_q.err;
  assign bus.valid_o     = valid_q;
  assign bus.busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_lampfpu_sqrt_post.sv
// Scoreboard bench for lampfpu_sqrt_post: stimulus pushes expected results, a monitor pops on valid_o.
module tb_lampfpu_sqrt_post;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    logic [15:0] res;
    logic        inv;
    logic        dbz;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  lampfpu_sqrt_post_if #(.FRAC_DW(16)) bus ();

  lampfpu_sqrt_post #(.FRAC_DW(16), .WDOG_CYC(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference: special-operand results straight from the IEEE-style tables
  function automatic exp_t ref_special(input logic inv, input logic sgn, input logic zero,
                                       input logic inf, input logic nan);
    exp_t x;
    x = '{res: 16'h0000, inv: 1'b0, dbz: 1'b0, err: 1'b0, cyc: 0};
    if (nan) x.res = 16'h7FC0;
    else if (!inv) begin
      if (zero)     x.res = sgn ? 16'h8000 : 16'h0000;
      else if (sgn) begin x.res = 16'h7FC0; x.inv = 1'b1; end
      else if (inf) x.res = 16'h7F80;
    end else begin
      if (zero)     begin x.res = sgn ? 16'hFF80 : 16'h7F80; x.dbz = 1'b1; end
      else if (sgn) begin x.res = 16'h7FC0; x.inv = 1'b1; end
      else if (inf) x.res = 16'h0000;
    end
    return x;
  endfunction

  // Reference: value = frac * 2^-15 * 2^e, rounded to an 8-bit significand with integer arithmetic
  function automatic exp_t ref_normal(input logic inv, input logic signed [7:0] k, input int frac);
    exp_t x;
    int e, p, sh, sig, rem, half, be;
    x = '{res: 16'h0000, inv: 1'b0, dbz: 1'b0, err: 1'b0, cyc: 0};
    e = k;
    if (inv) e = -e;
    if (frac < 16384) begin
      x.res = 16'h7FC0;
      x.err = 1'b1;
      return x;
    end
    p    = (frac >= 32768) ? 15 : 14;
    sh   = p - 7;
    sig  = frac >> sh;
    rem  = frac % (1 << sh);
    half = 1 << (sh - 1);
    if (rem > half || (rem == half && (sig % 2) == 1)) sig++;
    e = e + (p - 15);
    if (sig == 256) begin sig = 128; e++; end
    be = e + 127;
    if (be >= 255)    x.res = 16'h7F80;
    else if (be <= 0) x.res = 16'h0000;
    else              x.res = 16'((be << 7) | (sig % 128));
    return x;
  endfunction

  // Monitor: every valid_o strobe must match the oldest expected entry, including its cycle
  always @(negedge clk) begin
    if (!rst && bus.valid_o) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid actual=%0h required=none (cycle %0d)", bus.res_o, cyc);
      end else begin
        exp_t x;
        x = sb.pop_front();
        chk("res_o", bus.res_o, x.res);
        chk("invalid_o", bus.invalid_o, x.inv);
        chk("divByZero_o", bus.divByZero_o, x.dbz);
        chk("err_o", bus.err_o, x.err);
        chk("valid_cycle", cyc, x.cyc);
      end
    end
  end

  task automatic drive_idle();
    bus.start_i     = 1'b0;
    bus.isInv_i     = 1'b0;
    bus.halfExp_i   = 8'sd0;
    bus.sign_i      = 1'b0;
    bus.isZero_i    = 1'b0;
    bus.isInf_i     = 1'b0;
    bus.isNaN_i     = 1'b0;
    bus.fracValid_i = 1'b0;
    bus.frac_i      = 16'h0000;
  endtask

  task automatic pulse_start(input logic inv, input logic signed [7:0] k, input logic sgn,
                             input logic zero, input logic inf, input logic nan, input logic fv);
    bus.isInv_i     = inv;
    bus.halfExp_i   = k;
    bus.sign_i      = sgn;
    bus.isZero_i    = zero;
    bus.isInf_i     = inf;
    bus.isNaN_i     = nan;
    bus.fracValid_i = fv;
    bus.frac_i      = 16'($urandom);
    bus.start_i     = 1'b1;
    @(negedge clk);
    drive_idle();
  endtask

  task automatic do_special(input logic inv, input logic sgn, input logic zero,
                            input logic inf, input logic nan);
    exp_t x;
    x     = ref_special(inv, sgn, zero, inf, nan);
    x.cyc = cyc + 1;
    sb.push_back(x);
    pulse_start(inv, 8'($urandom), sgn, zero, inf, nan, 1'b0);
    @(negedge clk);
  endtask

  task automatic do_normal(input logic inv, input logic signed [7:0] k, input logic [15:0] frac,
                           input int dly, input logic fv_with_start, input logic busy_start);
    exp_t x;
    pulse_start(inv, k, 1'b0, 1'b0, 1'b0, 1'b0, fv_with_start);
    for (int i = 0; i < dly; i++) begin
      if (i == 0 && busy_start) begin
        bus.start_i = 1'b1;
        bus.isNaN_i = 1'b1;
      end
      @(negedge clk);
      drive_idle();
    end
    x     = ref_normal(inv, k, int'(frac));
    x.cyc = cyc + 2;
    sb.push_back(x);
    bus.fracValid_i = 1'b1;
    bus.frac_i      = frac;
    @(negedge clk);
    drive_idle();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int n0;
    drive_idle();
    repeat (3) @(negedge clk);
    chk("reset_res_o", bus.res_o, 16'h0000);
    chk("reset_valid_o", bus.valid_o, 0);
    chk("reset_busy_o", bus.busy_o, 0);
    chk("reset_flags", {bus.invalid_o, bus.divByZero_o, bus.err_o}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed operations
    do_normal(1'b0, 8'sd1, 16'h8000, 0, 1'b0, 1'b0);     // sqrt(4.0)
    do_normal(1'b0, 8'sd1, 16'h5A82, 2, 1'b0, 1'b0);     // sqrt(2.0)
    do_normal(1'b0, 8'sd0, 16'hFFFF, 1, 1'b0, 1'b0);     // rounding carry
    do_special(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);            // invsqrt(-0)
    do_special(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);            // sqrt(-1.0)
    do_special(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);            // sqrt(-0)
    do_special(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);            // invsqrt(+inf)
    do_special(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);            // sqrt(+inf)
    do_special(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);            // NaN
    do_normal(1'b0, 8'sd127, 16'hFFFF, 0, 1'b0, 1'b0);   // overflow to inf
    do_normal(1'b0, -8'sd127, 16'h8000, 0, 1'b0, 1'b0);  // underflow to zero
    do_normal(1'b0, -8'sd126, 16'h8000, 0, 1'b0, 1'b0);  // smallest normal
    do_normal(1'b1, -8'sd128, 16'h8000, 0, 1'b0, 1'b0);  // invsqrt overflow
    do_normal(1'b0, 8'sd3, 16'h3FFF, 1, 1'b0, 1'b0);     // fraction out of range
    do_normal(1'b0, 8'sd2, 16'h8180, 0, 1'b1, 1'b1);     // tie-to-even, ignored strobes

    // Randomised mix
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(3) == 0) begin
        int c;
        c = $urandom_range(3);
        do_special(1'($urandom), (c == 3) ? 1'b1 : 1'($urandom), c == 0, c == 1, c == 2);
      end else begin
        logic [15:0] f;
        f = ($urandom_range(9) == 0) ? 16'($urandom_range(16383)) : 16'($urandom_range(65535, 16384));
        do_normal(1'($urandom), 8'($urandom), f, $urandom_range(5),
                  1'($urandom), 1'($urandom));
      end
    end

    // Watchdog: no fraction ever arrives
    begin
      exp_t x;
      x     = '{res: 16'h7FC0, inv: 1'b0, dbz: 1'b0, err: 1'b1, cyc: 0};
      n0    = cyc;
      x.cyc = n0 + 33;
      sb.push_back(x);
      pulse_start(1'b0, 8'sd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("busy_in_wait", bus.busy_o, 1);
      repeat (33) @(negedge clk);
      chk("busy_after_wdog", bus.busy_o, 0);
    end

    // Reset in WAIT, then a stray fraction strobe
    pulse_start(1'b0, 8'sd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_res_o", bus.res_o, 16'h0000);
    chk("rst_mid_busy_o", bus.busy_o, 0);
    chk("rst_mid_flags", {bus.valid_o, bus.invalid_o, bus.divByZero_o, bus.err_o}, 0);
    bus.fracValid_i = 1'b1;
    bus.frac_i      = 16'h8000;
    @(negedge clk);
    drive_idle();
    repeat (4) @(negedge clk);
    chk("post_rst_res_o", bus.res_o, 16'h0000);
    chk("post_rst_busy_o", bus.busy_o, 0);

    // Drain: anything still queued never appeared
    for (int w = 0; w < 100 && sb.size() != 0; w++) @(negedge clk);
    while (sb.size() != 0) begin
      exp_t x;
      x = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_valid actual=none required=%0h at cycle %0d", x.res, x.cyc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
